// File: rtl/pulse_seq_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_seq_pkg
//  Purpose  : Shared types and constants for the pulse sequence scheduler:
//             FSM state encoding, default 0 V DAC code, slot index width and
//             the phase-timer width helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package pulse_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RD_HI  = 3'd1,
      S_RD_GAP = 3'd2,
      S_WR_HI  = 3'd3,
      S_WR_GAP = 3'd4,
      S_FINISH = 3'd5
   } pulse_state_t;

   // slot_idx is always 3 bits wide; this caps NUM_WRITE at 7
   localparam int         c_SLOT_W        = 3;
   localparam logic [7:0] c_ZERO_CODE_DEF = 8'd128;

   // Bits needed to hold (max width - 1); never narrower than one bit
   function automatic int timer_width(input int a, input int b, input int c);
      int max_w;
      max_w = a;
      if (b > max_w) max_w = b;
      if (c > max_w) max_w = c;
      return (max_w < 2) ? 1 : $clog2(max_w);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_seq_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_seq_scheduler_if
//  Purpose  : Control/status bundle between the key/control logic (master)
//             and the pulse sequence scheduler (slave).
//  Signals  : start, abort, read_code, write_code, wr_mask   master -> slave
//             dac_code, busy, done, slot_idx, sample_stb     slave -> master
//  Revision : 1.0  initial release
// ============================================================================
interface pulse_seq_scheduler_if
   import pulse_seq_pkg::*;
#(
   parameter int CODE_W    = 8,
   parameter int NUM_WRITE = 3
);
   logic                 start;
   logic                 abort;
   logic [CODE_W-1:0]    read_code;
   logic [CODE_W-1:0]    write_code;
   logic [NUM_WRITE-1:0] wr_mask;
   logic [CODE_W-1:0]    dac_code;
   logic                 busy;
   logic                 done;
   logic [c_SLOT_W-1:0]  slot_idx;
   logic                 sample_stb;

   modport master (
      output start, abort, read_code, write_code, wr_mask,
      input  dac_code, busy, done, slot_idx, sample_stb
   );

   modport slave (
      input  start, abort, read_code, write_code, wr_mask,
      output dac_code, busy, done, slot_idx, sample_stb
   );
endinterface
`default_nettype wire

// File: rtl/pulse_seq_scheduler_timer.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_phase_timer
//  Purpose  : Loadable down-counter timing one pulse/gap phase. Loaded with
//             (phase width - 1) on phase entry; the phase ends on the cycle
//             the count reads zero. Holds at zero when not reloaded.
//  Ports    : clk, reset_n       clock, async active-low reset
//             load, load_val     reload request and value
//             expired            count == 0
//             at_one             count == 1 (next cycle is the last one)
//  Revision : 1.0  initial release
// ============================================================================
module pulse_phase_timer #(
   parameter int WIDTH = 18
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             expired,
   output logic             at_one
);
   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= load_val;
      end else if (r_count != '0) begin
         r_count <= r_count - WIDTH'(1);
      end
   end

   assign expired = (r_count == '0);
   assign at_one  = (r_count == WIDTH'(1));
endmodule
`default_nettype wire

// File: rtl/pulse_seq_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_seq_scheduler
//  Purpose  : Sequences one pulse train onto the DAC code path:
//             READ, then NUM_WRITE x (WRITE, READ), each pulse followed by a
//             zero-level gap. Codes and write mask are latched at start.
//  Ports    : clk, reset_n   clock, async active-low reset
//             bus (slave)    start/abort/codes/mask in;
//                            dac_code/busy/done/slot_idx/sample_stb out
//  Options  : PULSE_SEQ_SAMPLE_STB_EN - when defined, sample_stb pulses on the
//             last cycle of every read pulse; otherwise it is tied low.
//  Revision : 1.0  initial release
// ============================================================================
module pulse_seq_scheduler
   import pulse_seq_pkg::*;
#(
   parameter int                CODE_W    = 8,
   parameter logic [CODE_W-1:0] ZERO_CODE = CODE_W'(c_ZERO_CODE_DEF),
   parameter int                READ_W    = 150000,
   parameter int                WRITE_W   = 100000,
   parameter int                GAP_W     = 100000,
   parameter int                NUM_WRITE = 3
) (
   input  logic                 clk,
   input  logic                 reset_n,
   pulse_seq_scheduler_if.slave bus
);
   localparam int                    c_TMR_W     = timer_width(READ_W, WRITE_W, GAP_W);
   localparam logic [c_TMR_W-1:0]    c_READ_LD   = c_TMR_W'(READ_W - 1);
   localparam logic [c_TMR_W-1:0]    c_WRITE_LD  = c_TMR_W'(WRITE_W - 1);
   localparam logic [c_TMR_W-1:0]    c_GAP_LD    = c_TMR_W'(GAP_W - 1);
   localparam logic [c_SLOT_W-1:0]   c_LAST_SLOT = c_SLOT_W'(NUM_WRITE);
   localparam int                    c_NSLOT     = 1 << c_SLOT_W;

   pulse_state_t         r_state, w_state_nxt;
   logic [c_SLOT_W-1:0]  r_slot, w_slot_nxt;
   logic [CODE_W-1:0]    r_read_code, w_read_code_nxt;
   logic [CODE_W-1:0]    r_write_code, w_write_code_nxt;
   logic [NUM_WRITE-1:0] r_wr_mask, w_wr_mask_nxt;
   logic [CODE_W-1:0]    r_dac_code, w_dac_code_nxt;
   logic                 r_busy, w_busy_nxt;
   logic                 r_done, w_done_nxt;
   logic                 w_accept;
   logic                 w_tmr_load;
   logic [c_TMR_W-1:0]   w_tmr_load_val;
   logic                 w_tmr_expired;
   logic                 w_tmr_at_one;
   logic [c_NSLOT-1:0]   w_slot_en;

   pulse_phase_timer #(.WIDTH(c_TMR_W)) u_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (w_tmr_load),
      .load_val (w_tmr_load_val),
      .expired  (w_tmr_expired),
      .at_one   (w_tmr_at_one)
   );

   // Per-slot write enable indexed by slot number; mask MSB is slot 1.
   // Slot 0 (first READ) and slots beyond NUM_WRITE never write.
   for (genvar k = 0; k < c_NSLOT; k++) begin : g_slot_en
      if (k >= 1 && k <= NUM_WRITE) begin : g_used
         assign w_slot_en[k] = w_wr_mask_nxt[NUM_WRITE-k];
      end else begin : g_none
         assign w_slot_en[k] = 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_slot  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_slot  <= w_slot_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next state, slot and phase-timer reload
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt    = r_state;
      w_slot_nxt     = r_slot;
      w_tmr_load     = 1'b0;
      w_tmr_load_val = '0;
      w_accept       = 1'b0;
      if (bus.abort) begin
         // abort outranks everything, including a start in IDLE
         w_state_nxt = S_IDLE;
         w_slot_nxt  = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  w_accept       = 1'b1;
                  w_state_nxt    = S_RD_HI;
                  w_tmr_load     = 1'b1;
                  w_tmr_load_val = c_READ_LD;
               end
            end
            S_RD_HI: begin
               if (w_tmr_expired) begin
                  w_state_nxt    = S_RD_GAP;
                  w_tmr_load     = 1'b1;
                  w_tmr_load_val = c_GAP_LD;
               end
            end
            S_RD_GAP: begin
               if (w_tmr_expired) begin
                  if (r_slot < c_LAST_SLOT) begin
                     w_state_nxt    = S_WR_HI;
                     w_slot_nxt     = r_slot + c_SLOT_W'(1);
                     w_tmr_load     = 1'b1;
                     w_tmr_load_val = c_WRITE_LD;
                  end else begin
                     w_state_nxt = S_FINISH;
                     w_slot_nxt  = '0;
                  end
               end
            end
            S_WR_HI: begin
               if (w_tmr_expired) begin
                  w_state_nxt    = S_WR_GAP;
                  w_tmr_load     = 1'b1;
                  w_tmr_load_val = c_GAP_LD;
               end
            end
            S_WR_GAP: begin
               if (w_tmr_expired) begin
                  w_state_nxt    = S_RD_HI;
                  w_tmr_load     = 1'b1;
                  w_tmr_load_val = c_READ_LD;
               end
            end
            S_FINISH: begin
               w_state_nxt = S_IDLE;
               w_slot_nxt  = '0;
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_slot_nxt  = '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Output decode from the next state so every output is a flop and
   // dac_code follows start by exactly one cycle. On the accepting edge
   // the live inputs are used because the latches load on that same edge.
   // ------------------------------------------------------------------
   always_comb begin
      w_read_code_nxt  = w_accept ? bus.read_code  : r_read_code;
      w_write_code_nxt = w_accept ? bus.write_code : r_write_code;
      w_wr_mask_nxt    = w_accept ? bus.wr_mask    : r_wr_mask;
      w_dac_code_nxt   = ZERO_CODE;
      case (w_state_nxt)
         S_RD_HI: w_dac_code_nxt = w_read_code_nxt;
         S_WR_HI: begin
            if (w_slot_en[w_slot_nxt]) begin
               w_dac_code_nxt = w_write_code_nxt;
            end
         end
         default: w_dac_code_nxt = ZERO_CODE;
      endcase
      w_busy_nxt = (w_state_nxt != S_IDLE) && (w_state_nxt != S_FINISH);
      w_done_nxt = (w_state_nxt == S_FINISH);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_read_code  <= '0;
         r_write_code <= '0;
         r_wr_mask    <= '0;
         r_dac_code   <= ZERO_CODE;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_read_code  <= w_read_code_nxt;
         r_write_code <= w_write_code_nxt;
         r_wr_mask    <= w_wr_mask_nxt;
         r_dac_code   <= w_dac_code_nxt;
         r_busy       <= w_busy_nxt;
         r_done       <= w_done_nxt;
      end
   end

   assign bus.dac_code = r_dac_code;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.slot_idx = r_slot;

`ifdef PULSE_SEQ_SAMPLE_STB_EN
   // Strobe the cycle whose remaining count will be zero: either a fresh
   // RD_HI of width 1, or staying in RD_HI while the count steps 1 -> 0.
   localparam bit c_READ_ONE = (READ_W == 1);
   logic r_sample_stb;
   logic w_sample_stb_nxt;

   assign w_sample_stb_nxt = (w_state_nxt == S_RD_HI) &&
                             (w_tmr_load ? c_READ_ONE : w_tmr_at_one);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sample_stb <= 1'b0;
      end else begin
         r_sample_stb <= w_sample_stb_nxt;
      end
   end

   assign bus.sample_stb = r_sample_stb;
`else
   logic w_unused_at_one;
   assign w_unused_at_one = w_tmr_at_one;
   assign bus.sample_stb  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pulse_seq_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pulse_seq_scheduler
//  Purpose  : Self-checking bench for pulse_seq_scheduler with small widths
//             (READ_W=6, WRITE_W=4, GAP_W=4, NUM_WRITE=3). Honours
//             PULSE_SEQ_SAMPLE_STB_EN for the strobe expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pulse_seq_scheduler;
   import pulse_seq_pkg::*;

   localparam int CODE_W    = 8;
   localparam int NUM_WRITE = 3;
`ifdef PULSE_SEQ_SAMPLE_STB_EN
   localparam bit STB_EN = 1'b1;
`else
   localparam bit STB_EN = 1'b0;
`endif

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   pulse_seq_scheduler_if #(.CODE_W(CODE_W), .NUM_WRITE(NUM_WRITE)) bus ();

   pulse_seq_scheduler #(
      .CODE_W    (CODE_W),
      .ZERO_CODE (8'd128),
      .READ_W    (6),
      .WRITE_W   (4),
      .GAP_W     (4),
      .NUM_WRITE (NUM_WRITE)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct packed {
      logic [7:0] dac;
      logic       busy;
      logic       done;
      logic [2:0] slot;
      logic       stb;
   } obs_t;

   typedef struct {
      int         cyc;
      logic [7:0] dac;
      logic       busy;
      logic       done;
      logic [2:0] slot;
   } vec_t;

   vec_t vecs[12];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic obs_t observe();
      obs_t o;
      o.dac  = bus.dac_code;
      o.busy = bus.busy;
      o.done = bus.done;
      o.slot = bus.slot_idx;
      o.stb  = bus.sample_stb;
      return o;
   endfunction

   // Expected outputs n cycles after the accepting edge, straight from the
   // pulse pattern: 6xRD, 4xGAP, then per slot 4xWR, 4xGAP, 6xRD, 4xGAP.
   function automatic obs_t model(input int n, input logic [2:0] mask,
                                  input logic [7:0] rd, input logic [7:0] wr);
      obs_t o;
      int   m, k, r;
      o = '{dac: 8'd128, busy: 1'b0, done: 1'b0, slot: 3'd0, stb: 1'b0};
      if (n < 6) begin
         o.dac  = rd;
         o.busy = 1'b1;
         o.stb  = STB_EN && (n == 5);
      end else if (n < 10) begin
         o.busy = 1'b1;
      end else if (n < 64) begin
         m      = n - 10;
         k      = m / 18 + 1;
         r      = m % 18;
         o.busy = 1'b1;
         o.slot = 3'(k);
         if (r < 4) begin
            o.dac = mask[3-k] ? wr : 8'd128;
         end else if (r >= 8 && r < 14) begin
            o.dac = rd;
            o.stb = STB_EN && (r == 13);
         end
      end else if (n == 64) begin
         o.done = 1'b1;
      end
      return o;
   endfunction

   task automatic run_train(input string tag, input logic [2:0] mask,
                            input logic [7:0] rd, input logic [7:0] wr,
                            input int last, input bit hold, input bit disturb,
                            input bit use_vecs);
      obs_t act, exp;
      int   vi       = 0;
      int   busy_cnt = 0;
      int   stb_cnt  = 0;
      bus.wr_mask    = mask;
      bus.read_code  = rd;
      bus.write_code = wr;
      bus.start      = 1'b1;
      for (int n = 0; n <= last; n++) begin
         tick();
         if (!hold) bus.start = 1'b0;
         act = observe();
         exp = model(n, mask, rd, wr);
         chk($sformatf("%s cycle %0d {dac,busy,done,slot,stb}", tag, n), 32'(act), 32'(exp));
         busy_cnt += int'(act.busy);
         stb_cnt  += int'(act.stb);
         if (use_vecs && vi < 12 && vecs[vi].cyc == n) begin
            chk($sformatf("%s vec%0d dac", tag, vi),  32'(act.dac),  32'(vecs[vi].dac));
            chk($sformatf("%s vec%0d busy", tag, vi), 32'(act.busy), 32'(vecs[vi].busy));
            chk($sformatf("%s vec%0d done", tag, vi), 32'(act.done), 32'(vecs[vi].done));
            chk($sformatf("%s vec%0d slot", tag, vi), 32'(act.slot), 32'(vecs[vi].slot));
            vi++;
         end
         if (disturb && n == 10) begin
            bus.start      = 1'b1;
            bus.write_code = 8'd150;
            bus.read_code  = 8'd77;
            bus.wr_mask    = 3'b000;
         end
         if (disturb && n == 11) bus.start = 1'b0;
      end
      if (last >= 64) begin
         chk({tag, " busy cycles"}, 32'(busy_cnt), 32'd64);
         chk({tag, " strobe count"}, 32'(stb_cnt), STB_EN ? 32'd4 : 32'd0);
      end
   endtask

   initial begin
      obs_t o;
      int   done_cnt;

      vecs[0]  = '{0,  8'd162, 1'b1, 1'b0, 3'd0};
      vecs[1]  = '{5,  8'd162, 1'b1, 1'b0, 3'd0};
      vecs[2]  = '{6,  8'd128, 1'b1, 1'b0, 3'd0};
      vecs[3]  = '{10, 8'd201, 1'b1, 1'b0, 3'd1};
      vecs[4]  = '{13, 8'd201, 1'b1, 1'b0, 3'd1};
      vecs[5]  = '{14, 8'd128, 1'b1, 1'b0, 3'd1};
      vecs[6]  = '{18, 8'd162, 1'b1, 1'b0, 3'd1};
      vecs[7]  = '{28, 8'd201, 1'b1, 1'b0, 3'd2};
      vecs[8]  = '{46, 8'd201, 1'b1, 1'b0, 3'd3};
      vecs[9]  = '{63, 8'd128, 1'b1, 1'b0, 3'd3};
      vecs[10] = '{64, 8'd128, 1'b0, 1'b1, 3'd0};
      vecs[11] = '{65, 8'd128, 1'b0, 1'b0, 3'd0};

      bus.start      = 1'b0;
      bus.abort      = 1'b0;
      bus.read_code  = 8'd0;
      bus.write_code = 8'd0;
      bus.wr_mask    = 3'b000;

      // reset values, while held and just after release
      repeat (3) @(posedge clk);
      #1;
      o = observe();
      chk("reset dac_code",   32'(o.dac),  32'd128);
      chk("reset busy",       32'(o.busy), 32'd0);
      chk("reset done",       32'(o.done), 32'd0);
      chk("reset slot_idx",   32'(o.slot), 32'd0);
      chk("reset sample_stb", 32'(o.stb),  32'd0);
      reset_n = 1'b1;
      tick();
      tick();
      chk("post-reset idle", 32'(observe()), 32'(obs_t'{8'd128, 1'b0, 1'b0, 3'd0, 1'b0}));

      // full train with checkpoint table, then sparse mask
      run_train("mask111", 3'b111, 8'd162, 8'd201, 65, 1'b0, 1'b0, 1'b1);
      run_train("mask010", 3'b010, 8'd162, 8'd201, 65, 1'b0, 1'b0, 1'b0);

      // start re-pulsed and inputs changed mid-train
      run_train("disturb", 3'b111, 8'd162, 8'd201, 65, 1'b0, 1'b1, 1'b0);

      // abort mid-train, stays idle, then a fresh train
      run_train("pre-abort", 3'b111, 8'd162, 8'd201, 19, 1'b0, 1'b0, 1'b0);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      o = observe();
      chk("abort dac_code", 32'(o.dac),  32'd128);
      chk("abort busy",     32'(o.busy), 32'd0);
      chk("abort done",     32'(o.done), 32'd0);
      chk("abort slot_idx", 32'(o.slot), 32'd0);
      done_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         done_cnt += int'(bus.done) + int'(bus.busy);
      end
      chk("after abort no done/busy", 32'(done_cnt), 32'd0);
      run_train("post-abort", 3'b111, 8'd162, 8'd201, 65, 1'b0, 1'b0, 1'b0);

      // abort wins over start in the same IDLE cycle
      bus.start = 1'b1;
      bus.abort = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      chk("abort beats start busy", 32'(bus.busy), 32'd0);
      tick();
      chk("abort beats start still idle", 32'(bus.busy), 32'd0);

      // asynchronous reset mid-train
      run_train("pre-reset", 3'b111, 8'd162, 8'd201, 29, 1'b0, 1'b0, 1'b0);
      reset_n = 1'b0;
      #1;
      o = observe();
      chk("async reset dac_code", 32'(o.dac),  32'd128);
      chk("async reset busy",     32'(o.busy), 32'd0);
      chk("async reset slot_idx", 32'(o.slot), 32'd0);
      tick();
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("released idle %0d", i), 32'(observe()),
             32'(obs_t'{8'd128, 1'b0, 1'b0, 3'd0, 1'b0}));
      end
      run_train("post-reset", 3'b101, 8'd90, 8'd240, 65, 1'b0, 1'b0, 1'b0);

      // start held high through FINISH: next train follows
      run_train("b2b", 3'b111, 8'd162, 8'd201, 64, 1'b1, 1'b0, 1'b0);
      tick();
      tick();
      chk("b2b restart busy",     32'(bus.busy),     32'd1);
      chk("b2b restart dac_code", 32'(bus.dac_code), 32'd162);
      chk("b2b restart slot_idx", 32'(bus.slot_idx), 32'd0);
      bus.start = 1'b0;
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
